muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers. It is the sequential companion to the combinational ALU controller path. It decodes R-type `OpCode`/`Funct` for mult/multu/div/divu/mthi/mtlo, runs a one-bit-per-cycle shift-add multiplier or restoring divider, and raises `Busy` so the datapath can stall. mfhi/mflo read the always-visible `Hi`/`Lo` ports.

## Interface
- `WIDTH`, default 32: operand width in bits. Legal range 4..64. Product is 2·WIDTH bits.
- `clk`  input  1  single clock. All state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `Start`  input  1  request valid for one cycle. Sampled only when `Busy`=0.
- `OpCode`  input  6  instruction opcode. Must be 0, otherwise the request is ignored.
- `Funct`  input  6  function field: 17 mthi, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu.
- `A`  input  WIDTH  rs operand (multiplicand, dividend, or mthi/mtlo data).
- `B`  input  WIDTH  rt operand (multiplier or divisor).
- `Busy`  output  1  operation in progress. Reset value 0.
- `Done`  output  1  one-cycle pulse when new mult/div results land in Hi/Lo. Reset value 0.
- `Hi`  output  WIDTH  HI register. Reset value 0.
- `Lo`  output  WIDTH  LO register. Reset value 0.

## Operation
- FSM states and transitions:
  - IDLE → MUL on an accepted mult/multu.
  - IDLE → DIV on an accepted div/divu.
  - MUL or DIV → FIX after WIDTH iterations.
  - FIX → IDLE.
- Accept condition: `Start`=1, `Busy`=0, `OpCode`=0, and `Funct` in the supported set. Any other `Funct` (including mfhi 16 and mflo 18) is ignored: no state change, no `Busy`, no `Done`.
- mthi/mtlo: `Hi`/`Lo` is loaded from `A` on the accept edge. No `Busy`, no `Done`.
- Signed ops (mult, div): the unit records operand signs and iterates on magnitudes.
  - FIX negates the product when the operand signs differ.
  - FIX negates the quotient when the signs differ.
  - FIX negates the remainder when the dividend is negative (remainder takes the dividend's sign).
- Unsigned ops (multu, divu): no sign handling. FIX writes results unchanged.
- Multiply: {Hi,Lo} = full 2·WIDTH-bit product. Divide: Lo = quotient, Hi = remainder.
- Divide by zero (signed or unsigned): Hi = original `A`, Lo = all ones. Latency is normal.
- Signed overflow (−2^(WIDTH−1) ÷ −1): Lo = −2^(WIDTH−1), Hi = 0.
- Operands are captured at the accept edge. Changes to `A`/`B` while `Busy` have no effect.

## Timing
- Accept edge E0: operands and the iteration counter (= WIDTH) are loaded, and `Busy` rises.
- Edges E1..E_WIDTH: one iteration per edge.
- Edge E_WIDTH+1 (FIX): Hi and Lo update together, `Done`=1 for one cycle, and `Busy` falls.
- `Busy` is high for exactly WIDTH+1 cycles. Results are readable in the `Done` cycle.
- A new `Start` is accepted in the `Done` cycle (back-to-back operation).
- `Start` while `Busy`=1 is ignored entirely, including mthi/mtlo.
- Reset asserted at any time:
  - `Busy`, `Done`, `Hi`, `Lo` go to 0 immediately.
  - FSM returns to IDLE.
  - An aborted operation never produces `Done`.

## Configuration
- `MULDIV_DIV_EN` defined: div/divu are supported as specified above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath and DIV state are not compiled.
  - Funct 26/27 are treated as unsupported (ignored, no `Busy`, no `Done`, Hi/Lo unchanged).
  - mult/multu/mthi/mtlo are unaffected.

## Test plan
All scenarios use WIDTH=32.
- mult A=0xFFFFFFFF, B=0x00000002 → `Busy` for 33 cycles, `Done` after edge E33, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
- multu with the same operands → Hi=0x00000001, Lo=0xFFFFFFFE.
- Signed and unsigned divide:
  - div A=0xFFFFFFF9, B=0x00000002 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - divu A=7, B=2 → Lo=3, Hi=1.
  - Issue divu back-to-back with `Start` in the `Done` cycle of the div; it must be accepted.
- Divide corner cases:
  - divu A=0x12345678, B=0 → Hi=0x12345678, Lo=0xFFFFFFFF.
  - div A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Ignored requests and reset:
  - mthi A=0xCAFEF00D while idle → Hi=0xCAFEF00D next cycle, `Done`=0.
  - Start mult, then at cycle 5 issue `Start` mthi → ignored.
  - Assert reset at cycle 10 → Hi=Lo=0, `Busy`=0 at once, and no `Done` ever appears.
- Build without `MULDIV_DIV_EN`: `Start` div → `Busy` stays 0, Hi/Lo unchanged. A following mult still completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider writing HI/LO.
// The divider (div/divu) is compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, FIX, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif
  state_t state, nxt;
  logic [2*WIDTH-1:0] p, prod;
  logic [WIDTH-1:0] opnd, mag_a, mag_b;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic accept, go_mul, go_div, sa, sb, neg_q, last;
  assign accept = Start && !Busy && OpCode == 6'd0;
  assign go_mul = accept && (Funct == 6'd24 || Funct == 6'd25);
`ifdef MULDIV_DIV_EN
  assign go_div = accept && (Funct == 6'd26 || Funct == 6'd27);
  logic neg_r, is_div;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH+1:0] diff;
  assign diff = {1'b0, p[2*WIDTH-1:WIDTH-1]} - {2'b0, opnd};
`else
  assign go_div = 1'b0;
`endif
  // Signed ops (even Funct) iterate on magnitudes; signs are fixed up in FIX.
  assign sa    = !Funct[0] && A[WIDTH-1];
  assign sb    = !Funct[0] && B[WIDTH-1];
  assign mag_a = sa ? -A : A;
  assign mag_b = sb ? -B : B;
  assign sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
  assign prod  = neg_q ? -p : p;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE && go_mul) nxt = MUL;
    if (state == MUL && last) nxt = FIX;
`ifdef MULDIV_DIV_EN
    if (state == IDLE && go_div) nxt = DIV;
    if (state == DIV && last) nxt = FIX;
`endif
    if (state == FIX) nxt = IDLE;
  end
  always_comb begin
    Busy = state != IDLE;
    last = cnt == CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      opnd <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      Done <= 1'b0;
      Hi <= '0;
      Lo <= '0;
`ifdef MULDIV_DIV_EN
      neg_r <= 1'b0;
      is_div <= 1'b0;
      a_orig <= '0;
`endif
    end else begin
      Done <= state == FIX;
      if (go_mul || go_div) begin
        p <= {{WIDTH{1'b0}}, go_mul ? mag_b : mag_a};
        opnd <= go_mul ? mag_a : mag_b;
        cnt <= CW'(WIDTH);
        neg_q <= sa ^ sb;
      end
      if (state == MUL) begin
        p <= {sum, p[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
      end
      if (accept && Funct == 6'd17) Hi <= A;
      if (accept && Funct == 6'd19) Lo <= A;
`ifdef MULDIV_DIV_EN
      if (go_mul || go_div) begin
        neg_r <= sa;
        is_div <= go_div;
        a_orig <= A;
      end
      // Restoring step: keep the trial difference only when it did not borrow.
      if (state == DIV) begin
        p <= diff[WIDTH+1] ? {p[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX && is_div) begin
        Hi <= opnd == '0 ? a_orig : neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        Lo <= opnd == '0 ? '1 : neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
      end
      if (state == FIX && !is_div) {Hi, Lo} <= prod;
`else
      if (state == FIX) {Hi, Lo} <= prod;
`endif
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, random ops against an arithmetic model, abort/ignore sequences.
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, Start = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;
  logic [W-1:0] A = '0, B = '0;
  logic Busy, Done;
  logic [W-1:0] Hi, Lo;
  int checks = 0, errors = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .OpCode(OpCode), .Funct(Funct),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f == 6'd24) res = sa * sb;
    else if (f == 6'd25) res = {32'd0, a} * {32'd0, b};
    else if (b == '0) res = {a, 32'hFFFFFFFF};
    else if (f == 6'd26) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else res = {a % b, a / b};
    return res;
  endfunction

  // Called at a negedge; returns at the Done negedge so the next call is back-to-back.
  task automatic run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
    int cyc, nb;
    Start = 1'b1; OpCode = '0; Funct = f; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    if (f == 6'd17 || f == 6'd19) begin
      chk({name, "_busy"}, Busy, 0);
      chk({name, "_done"}, Done, 0);
    end else begin
      chk({name, "_done_low"}, Done, 0);
      cyc = 0;
      nb = 0;
      while (!Done && cyc < 100) begin
        cyc++;
        nb += Busy;
        @(negedge clk);
      end
      chk({name, "_latency"}, cyc, W + 1);
      chk({name, "_busy_cycles"}, nb, W + 1);
      chk({name, "_busy_end"}, Busy, 0);
    end
    chk({name, "_hi"}, Hi, eh);
    chk({name, "_lo"}, Lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic ignore(input logic [5:0] op, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string name);
    int bad;
    bad = 0;
    Start = 1'b1; OpCode = op; Funct = f; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; OpCode = '0;
    repeat (W + 3) begin
      bad += (Busy || Done);
      @(negedge clk);
    end
    chk({name, "_quiet"}, bad, 0);
    chk({name, "_hi"}, Hi, m_hi);
    chk({name, "_lo"}, Lo, m_lo);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    reset = 1'b0;
    @(negedge clk);
    tbl.push_back('{6'd24, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE});
    tbl.push_back('{6'd25, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE});
`ifdef MULDIV_DIV_EN
    tbl.push_back('{6'd26, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    tbl.push_back('{6'd27, 32'h7, 32'h2, 32'h1, 32'h3});
    tbl.push_back('{6'd27, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF});
    tbl.push_back('{6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
    tbl.push_back('{6'd26, 32'h80000001, 32'h0, 32'h80000001, 32'hFFFFFFFF});
`endif
    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
    run(6'd17, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, m_lo, "mthi");
    run(6'd19, 32'h13572468, 32'h0, m_hi, 32'h13572468, "mtlo");
    ignore(6'd0, 6'd16, 32'h1, 32'h2, "mfhi");
    ignore(6'd0, 6'd18, 32'h1, 32'h2, "mflo");
    ignore(6'd1, 6'd24, 32'h3, 32'h4, "opcode");
`ifndef MULDIV_DIV_EN
    ignore(6'd0, 6'd26, 32'h7, 32'h2, "div_off");
    ignore(6'd0, 6'd27, 32'h7, 32'h2, "divu_off");
    run(6'd24, 32'h3, 32'h5, 32'h0, 32'hF, "mult_after_div");
`endif
    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      logic [W-1:0] a, b;
      logic [63:0] e;
`ifdef MULDIV_DIV_EN
      f = 6'd24 + 6'($urandom_range(0, 3));
`else
      f = 6'd24 + 6'($urandom_range(0, 1));
`endif
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 9)) : W'($urandom);
      e = model(f, a, b);
      run(f, a, b, e[63:32], e[31:0], $sformatf("rand%0d", i));
    end
    run(6'd17, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, m_lo, "pre_hi");
    run(6'd19, 32'h5A5A5A5A, 32'h0, m_hi, 32'h5A5A5A5A, "pre_lo");
    Start = 1'b1; Funct = 6'd24; A = 32'h1234; B = 32'h5678;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Start = 1'b1; Funct = 6'd17; A = 32'hDEADBEEF;
    @(negedge clk);
    Start = 1'b0;
    chk("busy_mthi_hi", Hi, m_hi);
    chk("busy_mthi_busy", Busy, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_hi", Hi, 0);
    chk("abort_lo", Lo, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (60) begin
      seen += Done;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    m_hi = '0;
    m_lo = '0;
    run(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, "post_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
